id_stage_skid: RTL
==================

Name: id_stage_skid

Overview:
- Parametrised successor to the decode pipeline register. It sits between the decoder and the execute stage.
- Captures one decoded instruction bundle plus its PC per accepted cycle.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is fully registered, pipeline flush, and illegal-instruction squashing of register writeback.
- Payload widths are generic, so wider immediates and op encodings are supported without edits.

Parameters:
- DataWidth, 32, width of imm, exp_code and pc
- RegAddrWidth, 5, register address width
- AluOpWidth, 5, ALU op field width
- LsuOpWidth, 4, LSU op field width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_flush  in  1  kill all held and incoming instructions this cycle
- i_valid  in  1  upstream bundle valid
- o_ready  out  1  stage can accept a bundle
- i_pc  in  DataWidth  PC of the incoming bundle
- i_imm  in  DataWidth  decoded immediate
- i_rd_addr / i_rs1_addr / i_rs2_addr  in  RegAddrWidth each  register addresses
- i_rd_en, i_use_imm, i_alu, i_lsu, i_br, i_illegal  in  1 each  decode flags
- i_exp_code  in  DataWidth  exception cause
- i_alu_op  in  AluOpWidth;  i_lsu_op  in  LsuOpWidth
- o_valid  out  1  downstream bundle valid
- i_ready  in  1  downstream accepts
- o_pc, o_imm, o_rd_addr, o_rs1_addr, o_rs2_addr, o_rd_en, o_use_imm, o_alu, o_lsu, o_br, o_illegal, o_exp_code, o_alu_op, o_lsu_op  out  widths as the matching inputs  registered bundle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - Every output register is 0, including o_rd_en and o_valid.
  - Skid entry is cleared (valid 0, payload 0).
  - o_ready reads 1 the first cycle after rst deasserts.
- Handshakes: accept = i_valid & o_ready; deliver = o_valid & i_ready.
- Latency: 1 cycle. A bundle accepted at edge N is on the outputs with o_valid=1 after edge N.
- State machine, 2-bit registered state:
  - EMPTY: o_valid=0.
  - ONE: main register valid, skid empty.
  - TWO: main and skid both valid.
- o_ready is a pure register decode: o_ready = (state != TWO). It has no combinational path from i_ready.
- Transitions, flush low:
  - EMPTY: accept -> ONE, load main.
  - ONE, accept & deliver -> ONE, load main.
  - ONE, accept & !deliver -> TWO, load skid.
  - ONE, !accept & deliver -> EMPTY.
  - ONE, neither -> hold.
  - TWO, deliver -> ONE, main <= skid, skid cleared. No accept is possible in TWO.
  - TWO, !deliver -> hold. Outputs stay stable while o_valid & !i_ready.
- Flush:
  - i_flush=1 forces state to EMPTY, o_valid to 0 and skid valid to 0 at the next edge.
  - Flush has priority over a same-cycle accept; the incoming bundle is dropped.
  - Payload registers may keep stale data, but o_rd_en is forced 0.
- Illegal squash: any bundle with i_illegal=1 is stored with rd_en=0. i_exp_code, i_pc and i_illegal are stored unchanged.
- Ordering: strict FIFO. The skid entry is never delivered before the main entry.
- Reset mid-operation: both entries are discarded immediately and asynchronously; no bundle is delivered afterwards.
- Widths: all fields pass through unmodified, with no extension or truncation.

Optional Feature:
- Macro ID_STAGE_STALL_CNT_EN.
- When defined:
  - Adds output o_stall_cnt, 32 bits, reset 0.
  - Increments once per cycle where o_valid & !i_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst only; flush does not clear it.
- When undefined: the port and counter are absent, with no other behaviour difference.

Test Plan:
- Reset then stream, i_ready=1: three bundles pc=0x100/0x104/0x108, i_valid=1 in consecutive cycles -> o_valid=1 with o_pc 0x100/0x104/0x108 on cycles 1/2/3; o_ready stays 1.
- Backpressure fill: i_ready=0, push pc=0x200 then 0x204 -> o_pc holds 0x200; o_ready=0 after second accept. Raise i_ready -> 0x200 then 0x204 delivered in order, o_ready=1 again.
- Flush with same-cycle accept: state TWO, then i_flush=1 with i_valid=1 pc=0x300 -> next cycle o_valid=0, o_rd_en=0, state EMPTY; 0x300 never appears.
- Illegal squash: i_illegal=1, i_rd_en=1, i_exp_code=2, rd=5 -> o_illegal=1, o_rd_en=0, o_exp_code=2, o_rd_addr=5.
- Async reset mid-stream: assert rst between edges while in TWO -> o_valid=0 and o_rd_en=0 immediately; after release o_ready=1 and the held bundles are not delivered.
- With ID_STAGE_STALL_CNT_EN: hold o_valid=1, i_ready=0 for 7 cycles -> o_stall_cnt=7; apply flush -> value stays 7.

Source files
------------

// File: rtl/id_stage_skid.sv
// Decode-to-execute pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush and illegal-instruction writeback squash. Optional stall counter: ID_STAGE_STALL_CNT_EN.
module id_stage_skid #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5,
    parameter int AluOpWidth   = 5,
    parameter int LsuOpWidth   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DataWidth-1:0]    i_pc,
    input  logic [DataWidth-1:0]    i_imm,
    input  logic [RegAddrWidth-1:0] i_rd_addr,
    input  logic [RegAddrWidth-1:0] i_rs1_addr,
    input  logic [RegAddrWidth-1:0] i_rs2_addr,
    input  logic                    i_rd_en,
    input  logic                    i_use_imm,
    input  logic                    i_alu,
    input  logic                    i_lsu,
    input  logic                    i_br,
    input  logic                    i_illegal,
    input  logic [DataWidth-1:0]    i_exp_code,
    input  logic [AluOpWidth-1:0]   i_alu_op,
    input  logic [LsuOpWidth-1:0]   i_lsu_op,
    output logic                    o_valid,
    input  logic                    i_ready,
`ifdef ID_STAGE_STALL_CNT_EN
    output logic [31:0]             o_stall_cnt,
`endif
    output logic [DataWidth-1:0]    o_pc,
    output logic [DataWidth-1:0]    o_imm,
    output logic [RegAddrWidth-1:0] o_rd_addr,
    output logic [RegAddrWidth-1:0] o_rs1_addr,
    output logic [RegAddrWidth-1:0] o_rs2_addr,
    output logic                    o_rd_en,
    output logic                    o_use_imm,
    output logic                    o_alu,
    output logic                    o_lsu,
    output logic                    o_br,
    output logic                    o_illegal,
    output logic [DataWidth-1:0]    o_exp_code,
    output logic [AluOpWidth-1:0]   o_alu_op,
    output logic [LsuOpWidth-1:0]   o_lsu_op
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DataWidth-1:0]    pc;
        logic [DataWidth-1:0]    imm;
        logic [DataWidth-1:0]    exp_code;
        logic [RegAddrWidth-1:0] rd_addr;
        logic [RegAddrWidth-1:0] rs1_addr;
        logic [RegAddrWidth-1:0] rs2_addr;
        logic                    rd_en;
        logic                    use_imm;
        logic                    alu;
        logic                    lsu;
        logic                    br;
        logic                    illegal;
        logic [AluOpWidth-1:0]   alu_op;
        logic [LsuOpWidth-1:0]   lsu_op;
    } bundle_t;

    state_t  state_q, state_d;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    bundle_t in_b;
    logic    accept;
    logic    deliver;

    // Ready depends only on the state register, so upstream sees no path from i_ready.
    assign o_ready = (state_q != TWO);
    assign o_valid = (state_q != EMPTY);

    always_comb begin
        in_b          = '0;
        in_b.pc       = i_pc;
        in_b.imm      = i_imm;
        in_b.exp_code = i_exp_code;
        in_b.rd_addr  = i_rd_addr;
        in_b.rs1_addr = i_rs1_addr;
        in_b.rs2_addr = i_rs2_addr;
        in_b.rd_en    = i_rd_en & ~i_illegal;
        in_b.use_imm  = i_use_imm;
        in_b.alu      = i_alu;
        in_b.lsu      = i_lsu;
        in_b.br       = i_br;
        in_b.illegal  = i_illegal;
        in_b.alu_op   = i_alu_op;
        in_b.lsu_op   = i_lsu_op;
    end

    always_comb begin
        accept  = i_valid & o_ready;
        deliver = o_valid & i_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d      = EMPTY;
            main_d.rd_en = 1'b0;
            skid_d       = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_b;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_d = in_b;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_b;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ID_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_valid && !i_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    assign o_pc       = main_q.pc;
    assign o_imm      = main_q.imm;
    assign o_exp_code = main_q.exp_code;
    assign o_rd_addr  = main_q.rd_addr;
    assign o_rs1_addr = main_q.rs1_addr;
    assign o_rs2_addr = main_q.rs2_addr;
    assign o_rd_en    = main_q.rd_en;
    assign o_use_imm  = main_q.use_imm;
    assign o_alu      = main_q.alu;
    assign o_lsu      = main_q.lsu;
    assign o_br       = main_q.br;
    assign o_illegal  = main_q.illegal;
    assign o_alu_op   = main_q.alu_op;
    assign o_lsu_op   = main_q.lsu_op;

endmodule
